// File: rtl/display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// display_scan_ctrl
//   Scan/refresh controller feeding the 4-digit seven-segment multiplexer.
//   It divides clk into per-digit scan slots and double-buffers display data
//   behind a valid/ready load port. New data commits only on a frame boundary,
//   so a digit never tears mid-frame. It also provides per-digit blink.
//
//   Optional feature macro: LZ_BLANK_EN (leading-zero blanking of digits 3..1).
//
// Parameters
//   SCAN_DIV      clk cycles per digit slot (>= 2)
//   BLINK_FRAMES  full frames per blink half-period (>= 1)
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   en                 scan enable; 0 freezes the prescaler, scan and blink
//   load_valid         load request
//   load_hexs/point/blank  data for the shadow buffer
//   blink_mask         live per-digit blink enable (not latched)
//   load_ready         shadow buffer free (combinational from pending)
//   scan               current digit index 0..3
//   hexs, point        committed digit nibbles / decimal-point bits
//   les                per-digit blank after blink / blanking (combinational)
//   frame_tick         1-cycle pulse on the scan 3->0 wrap (combinational)
// ---------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_valid,
    input  logic [15:0] load_hexs,
    input  logic [3:0]  load_point,
    input  logic [3:0]  load_blank,
    input  logic [3:0]  blink_mask,
    output logic        load_ready,
    output logic [1:0]  scan,
    output logic [15:0] hexs,
    output logic [3:0]  point,
    output logic [3:0]  les,
    output logic        frame_tick
);

    localparam int unsigned CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               blink_phase;
    logic [3:0]         blank_r;
    logic               pending;
    logic [15:0]        shadow_hexs;
    logic [3:0]         shadow_point;
    logic [3:0]         shadow_blank;

    logic tick;
    logic frame_end;
    logic accept;
    logic [3:0] lz;

    // Slot tick, frame boundary and load handshake
    assign tick       = en & (cnt == CNT_W'(SCAN_DIV - 1));
    assign frame_end  = tick & (scan == 2'd3);
    assign frame_tick = frame_end;
    assign load_ready = ~pending;
    assign accept     = load_valid & load_ready;

    // Prescaler and digit scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            scan <= 2'd0;
        end else if (en) begin
            if (tick) begin
                cnt  <= '0;
                scan <= scan + 2'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Shadow buffer and frame-aligned commit. Accept needs pending=0 and commit
    // needs pending=1, so they never coincide: data accepted on a frame_end
    // cycle waits for the following frame_end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending      <= 1'b0;
            shadow_hexs  <= 16'h0000;
            shadow_point <= 4'hF;
            shadow_blank <= 4'h0;
            hexs         <= 16'h0000;
            point        <= 4'hF;
            blank_r      <= 4'h0;
        end else if (accept) begin
            pending      <= 1'b1;
            shadow_hexs  <= load_hexs;
            shadow_point <= load_point;
            shadow_blank <= load_blank;
        end else if (frame_end && pending) begin
            pending <= 1'b0;
            hexs    <= shadow_hexs;
            point   <= shadow_point;
            blank_r <= shadow_blank;
        end
    end

    // Blink phase advances once every BLINK_FRAMES frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

`ifdef LZ_BLANK_EN
    // A digit is a leading zero when it and every higher nibble are zero;
    // digit 0 always shows so an all-zero value reads "0".
    always_comb begin
        lz    = 4'h0;
        lz[3] = (hexs[15:12] == 4'h0);
        lz[2] = lz[3] & (hexs[11:8] == 4'h0);
        lz[1] = lz[2] & (hexs[7:4] == 4'h0);
    end
`else
    assign lz = 4'h0;
`endif

    assign les = blank_r | (blink_mask & {4{blink_phase}}) | lz;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Directed bench for display_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
//   Inputs are driven and outputs sampled on the falling clock edge. Accepted
//   loads push their expected committed value onto a queue; each observed
//   commit pops and compares it.
// ---------------------------------------------------------------------------
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load_valid;
    logic [15:0] load_hexs;
    logic [3:0]  load_point;
    logic [3:0]  load_blank;
    logic [3:0]  blink_mask;
    logic        load_ready;
    logic [1:0]  scan;
    logic [15:0] hexs;
    logic [3:0]  point;
    logic [3:0]  les;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    // {blank, point, hexs} of each accepted load, in commit order
    logic [23:0] sb_q[$];
    logic [15:0] cur_hexs;

    display_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (load_valid),
        .load_hexs  (load_hexs),
        .load_point (load_point),
        .load_blank (load_blank),
        .blink_mask (blink_mask),
        .load_ready (load_ready),
        .scan       (scan),
        .hexs       (hexs),
        .point      (point),
        .les        (les),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a load for one cycle; push it when the bench expects acceptance
    task automatic load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] b,
                        input bit expect_accept);
        load_valid = 1'b1;
        load_hexs  = h;
        load_point = p;
        load_blank = b;
        if (expect_accept) sb_q.push_back({b, p, h});
        step();
        load_valid = 1'b0;
    endtask

    // Wait for the next frame boundary, then compare the committed data
    task automatic wait_commit(input string tag, output int n);
        logic [23:0] exp;
        n = 0;
        while (frame_tick !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 64), 32'd1);
        if (n < 64) begin
            check({tag, "_hold"}, 32'(hexs), 32'(cur_hexs));
            step();
            n++;
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
            end else begin
                exp = sb_q.pop_front();
                check({tag, "_hexs"}, 32'(hexs), 32'(exp[15:0]));
                check({tag, "_point"}, 32'(point), 32'(exp[19:16]));
                check({tag, "_ready"}, 32'(load_ready), 32'd1);
                cur_hexs = exp[15:0];
            end
        end
    endtask

    initial begin
        int n;
        logic [15:0] lz_vals [3];
        logic [3:0]  lz_les  [3];
        lz_vals = '{16'h0050, 16'h0000, 16'h1000};
`ifdef LZ_BLANK_EN
        lz_les  = '{4'b1100, 4'b1110, 4'b0000};
`else
        lz_les  = '{4'b0000, 4'b0000, 4'b0000};
`endif
        rst = 1'b1; en = 1'b0; load_valid = 1'b0;
        load_hexs = 16'h0; load_point = 4'hF; load_blank = 4'h0; blink_mask = 4'h0;
        cur_hexs = 16'h0000;

        // 1: reset state, then scan sequence and frame_tick
        step(); step();
        check("rst_scan", 32'(scan), 32'd0);
        check("rst_hexs", 32'(hexs), 32'h0000);
        check("rst_point", 32'(point), 32'hF);
        check("rst_ready", 32'(load_ready), 32'd1);
`ifdef LZ_BLANK_EN
        check("rst_les", 32'(les), 32'hE);
`else
        check("rst_les", 32'(les), 32'h0);
`endif
        rst = 1'b0; en = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("scan_seq", 32'(scan), 32'((i / 4) % 4));
            check("frame_tick", 32'(frame_tick), 32'(i % 16 == 15));
        end

        // 2/3: accept 1234 at scan=1, ABCD ignored while busy
        load(16'h1234, 4'h7, 4'h0, 1'b1);
        check("ready_drop", 32'(load_ready), 32'd0);
        load_valid = 1'b1; load_hexs = 16'hABCD;
        for (int i = 0; i < 5; i++) step();
        load_valid = 1'b0;
        wait_commit("commit_1234", n);

        // 3: accept on a frame_end cycle commits one frame later
        for (int i = 0; i < 15; i++) step();
        check("fe_tick", 32'(frame_tick), 32'd1);
        load(16'h9876, 4'h5, 4'h0, 1'b1);
        check("fe_no_commit", 32'(hexs), 32'h1234);
        check("fe_ready", 32'(load_ready), 32'd0);
        wait_commit("commit_fe", n);
        check("fe_latency", 32'(n), 32'd16);

        // 4: blink on digit 2, toggling every 32 cycles
        blink_mask = 4'b0100;
        for (int k = 65; k <= 128; k++) begin
            step();
            check("blink", 32'(les), ((k / 32) % 2 == 1) ? 32'h4 : 32'h0);
        end
        blink_mask = 4'h0;

        // 5: en=0 freezes scan and commit while a load is pending
        load(16'h4321, 4'hA, 4'b0001, 1'b1);
        check("p_ready", 32'(load_ready), 32'd0);
        for (int i = 0; i < 8; i++) step();
        check("p_scan2", 32'(scan), 32'd2);
        en = 1'b0;
        for (int i = 0; i < 50; i++) step();
        check("hold_scan", 32'(scan), 32'd2);
        check("hold_hexs", 32'(hexs), 32'h9876);
        check("hold_ready", 32'(load_ready), 32'd0);
        en = 1'b1;
        wait_commit("commit_en", n);
        check("en_latency", 32'(n), 32'd7);
        check("blank_les", 32'(les), 32'h1);

        // 5: reset while pending discards the shadow
        load(16'h5555, 4'h0, 4'h0, 1'b1);
        check("r_ready", 32'(load_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("async_hexs", 32'(hexs), 32'h0000);
        sb_q.delete();
        cur_hexs = 16'h0000;
        step();
        rst = 1'b0;
        check("r_point", 32'(point), 32'hF);
        check("r_ready2", 32'(load_ready), 32'd1);
        check("r_scan", 32'(scan), 32'd0);
        for (int i = 0; i < 20; i++) step();
        check("r_no_commit", 32'(hexs), 32'h0000);

        // 6: leading-zero blanking (none without the macro)
        for (int i = 0; i < 3; i++) begin
            load(lz_vals[i], 4'hF, 4'h0, 1'b1);
            wait_commit("commit_lz", n);
            check("lz_les", 32'(les), 32'(lz_les[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
